// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetch with a prefetch FIFO, credit-limited requests and flush on redirect
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_incr_o
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    logic [31:0]   fpc;
    logic [31:0]   q_pc [DEPTH];
    logic [31:0]   q_in [DEPTH];
    logic [31:0]   pend [DEPTH];
    logic [AW-1:0] q_rd, q_wr, p_rd, p_wr;
    logic [CW-1:0] count, osc, dsc;
    logic [CW:0]   used;
    logic          hs, rv, drop, push, pop;

    assign used          = {1'b0, osc} + {1'b0, count};
    assign imem_req_o    = !rst && !redirect_i && (used < CAP);
    assign imem_addr_o   = fpc;
    assign hs            = imem_req_o && imem_gnt_i;
    assign rv            = imem_rvalid_i && (osc != '0);
    assign drop          = rv && (dsc != '0);
    assign push          = rv && !drop && !redirect_i;
    assign instr_valid_o = !rst && !redirect_i && (count != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = instr_valid_o ? q_in[q_rd] : 32'h0000_0013;
    assign pc_o          = instr_valid_o ? q_pc[q_rd] : 32'h0000_0000;
    assign pc_incr_o     = pc_o + 32'd4;

    // Control state: fetch pointer, credit/discard counters and queue pointers; redirect flushes everything buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc   <= RESET_PC;
            osc   <= '0;
            dsc   <= '0;
            count <= '0;
            q_rd  <= '0;
            q_wr  <= '0;
            p_rd  <= '0;
            p_wr  <= '0;
        end else begin
            osc <= osc + CW'(hs) - CW'(rv);
            if (redirect_i) begin
                fpc   <= redirect_pc_i & 32'hFFFF_FFFC;
                dsc   <= dsc + osc - CW'(rv);
                count <= '0;
                q_rd  <= '0;
                q_wr  <= '0;
                p_rd  <= '0;
                p_wr  <= '0;
            end else begin
                if (hs) begin
                    fpc  <= fpc + 32'd4;
                    p_wr <= p_wr + AW'(1);
                end
                if (drop) dsc <= dsc - CW'(1);
                if (push) begin
                    q_wr <= q_wr + AW'(1);
                    p_rd <= p_rd + AW'(1);
                end
                if (pop) q_rd <= q_rd + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage: pending-pc queue records granted addresses, FIFO pairs each accepted word with its pc
    always_ff @(posedge clk) begin
        if (hs) pend[p_wr] <= fpc;
        if (push) begin
            q_pc[q_wr] <= pend[p_rd];
            q_in[q_wr] <= imem_rdata_i;
        end
    end
endmodule
